// File: rtl/flash_sample_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : flash_sample_streamer
//  Description : Plays an audio clip stored in an Avalon-MM flash region.
//                Each flash word holds N = DATA_W/SAMPLE_W samples (lanes,
//                lane 0 in the least significant bits). Every accepted
//                sample_tick produces one sample. The word is read from flash
//                only when it is not already buffered. Playback runs forward
//                or in reverse, and either loops or stops with done at the
//                clip boundary.
//
//  Ports       : clk, rst (async, active-low)
//                sample_tick, play, dir, loop, restart   - playback control
//                flsh_address, flsh_read, flsh_byteenable - Avalon-MM master
//                flsh_waitrequest, flsh_readdata,
//                flsh_readdatavalid                       - Avalon-MM slave resp
//                audio_out, audio_valid                   - sample stream
//                done, overrun                            - sticky status
//
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_sample_streamer #(
  parameter int          ADDR_W     = 23,
  parameter int          DATA_W     = 32,
  parameter int          SAMPLE_W   = 16,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 'h7FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic                  play,
  input  logic                  dir,
  input  logic                  loop,
  input  logic                  restart,
  output logic [ADDR_W-1:0]     flsh_address,
  output logic                  flsh_read,
  input  logic                  flsh_waitrequest,
  input  logic [DATA_W-1:0]     flsh_readdata,
  input  logic                  flsh_readdatavalid,
  output logic [DATA_W/8-1:0]   flsh_byteenable,
  output logic [SAMPLE_W-1:0]   audio_out,
  output logic                  audio_valid,
  output logic                  done,
  output logic                  overrun
);

  localparam int                  c_LANES     = DATA_W / SAMPLE_W;
  localparam int                  c_LANE_W    = (c_LANES > 1) ? $clog2(c_LANES) : 1;
  localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(c_LANES - 1);
  localparam logic [ADDR_W-1:0]   c_START     = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0]   c_END       = ADDR_W'(END_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_buf;
  logic                r_buf_valid;
  logic [c_LANE_W-1:0] r_lane;
  logic [SAMPLE_W-1:0] r_audio_out;
  logic                r_done;
  logic                r_overrun;
  logic                r_restart_pend;

  // Lane views of the buffered word and of the incoming read data
  logic [SAMPLE_W-1:0] w_buf_lane [c_LANES];
  logic [SAMPLE_W-1:0] w_rd_lane  [c_LANES];

  for (genvar k = 0; k < c_LANES; k++) begin : g_lane
    assign w_buf_lane[k] = r_buf[k*SAMPLE_W +: SAMPLE_W];
    assign w_rd_lane[k]  = flsh_readdata[k*SAMPLE_W +: SAMPLE_W];
  end

  logic                w_tick_accept;
  logic                w_busy_tick;
  logic                w_apply_restart;
  logic [ADDR_W-1:0]   w_restart_addr;
  logic [c_LANE_W-1:0] w_restart_lane;
  logic                w_word_done;
  logic                w_at_edge;
  logic [c_LANE_W-1:0] w_lane_step;
  logic [ADDR_W-1:0]   w_addr_step;
  logic [ADDR_W-1:0]   w_addr_wrap;

  assign w_tick_accept = sample_tick & play & ~r_done;
  assign w_busy_tick   = sample_tick & play & (r_state != S_IDLE);

  // A restart is taken immediately in IDLE. Otherwise it waits until the
  // transaction in flight finishes, which is the EMIT -> IDLE edge.
  assign w_apply_restart = ((r_state == S_IDLE) & restart) |
                           ((r_state == S_EMIT) & (restart | r_restart_pend));

  assign w_restart_addr = dir ? c_END : c_START;
  assign w_restart_lane = dir ? c_LAST_LANE : '0;

  // Direction-dependent stepping. The lane index is kept across a direction
  // change, so a reversal mid-word continues from the current lane.
  assign w_word_done = dir ? (r_lane == '0) : (r_lane == c_LAST_LANE);
  assign w_at_edge   = dir ? (r_addr == c_START) : (r_addr == c_END);
  assign w_lane_step = dir ? (r_lane - 1'b1) : (r_lane + 1'b1);
  assign w_addr_step = dir ? (r_addr - 1'b1) : (r_addr + 1'b1);
  assign w_addr_wrap = dir ? c_END : c_START;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    flsh_read   = 1'b0;
    audio_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A restart in the same cycle swallows the tick
        if (!restart && w_tick_accept) begin
          w_state_nxt = r_buf_valid ? S_EMIT : S_REQ;
        end
      end
      S_REQ: begin
        flsh_read = 1'b1;
        if (!flsh_waitrequest) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flsh_readdatavalid) begin
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        audio_valid = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: address, lane, word buffer, sample register, status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr         <= c_START;
      r_buf          <= '0;
      r_buf_valid    <= 1'b0;
      r_lane         <= '0;
      r_audio_out    <= '0;
      r_done         <= 1'b0;
      r_overrun      <= 1'b0;
      r_restart_pend <= 1'b0;
    end else if (w_apply_restart) begin
      r_addr         <= w_restart_addr;
      r_lane         <= w_restart_lane;
      r_buf_valid    <= 1'b0;
      r_done         <= 1'b0;
      r_overrun      <= 1'b0;
      r_restart_pend <= 1'b0;
    end else begin
      if (w_busy_tick) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_tick_accept && r_buf_valid) begin
            r_audio_out <= w_buf_lane[r_lane];
          end
        end
        S_REQ: begin
          if (restart) begin
            r_restart_pend <= 1'b1;
          end
        end
        S_WAIT: begin
          if (restart) begin
            r_restart_pend <= 1'b1;
          end
          if (flsh_readdatavalid) begin
            r_buf       <= flsh_readdata;
            r_buf_valid <= 1'b1;
            r_audio_out <= w_rd_lane[r_lane];
          end
        end
        S_EMIT: begin
          if (!w_word_done) begin
            r_lane <= w_lane_step;
          end else begin
            r_buf_valid <= 1'b0;
            r_lane      <= dir ? c_LAST_LANE : '0;
            if (!w_at_edge) begin
              r_addr <= w_addr_step;
            end else if (loop) begin
              r_addr <= w_addr_wrap;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign flsh_address    = r_addr;
  assign flsh_byteenable = '1;
  assign audio_out       = r_audio_out;
  assign done            = r_done;
  assign overrun         = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_flash_sample_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flash_sample_streamer
//  Description : Self-checking bench for flash_sample_streamer. A clip-level
//                reference model tracks the absolute sample index, buffer
//                ownership and the sticky flags. A responsive Avalon slave
//                serves words from a small memory with random stall and
//                latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_sample_streamer;

  localparam int ADDR_W   = 23;
  localparam int DATA_W   = 32;
  localparam int SAMPLE_W = 16;
  localparam int N        = DATA_W / SAMPLE_W;
  localparam int START    = 0;
  localparam int ENDA     = 2;
  localparam int FIRST    = START * N;
  localparam int LAST     = ENDA * N + N - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                sample_tick = 1'b0;
  logic                play = 1'b0;
  logic                dir = 1'b0;
  logic                loop = 1'b0;
  logic                restart = 1'b0;
  logic [ADDR_W-1:0]   flsh_address;
  logic                flsh_read;
  logic                flsh_waitrequest = 1'b0;
  logic [DATA_W-1:0]   flsh_readdata = '0;
  logic                flsh_readdatavalid = 1'b0;
  logic [DATA_W/8-1:0] flsh_byteenable;
  logic [SAMPLE_W-1:0] audio_out;
  logic                audio_valid;
  logic                done;
  logic                overrun;

  always #5 clk = ~clk;

  flash_sample_streamer #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .SAMPLE_W  (SAMPLE_W),
    .START_ADDR(START),
    .END_ADDR  (ENDA)
  ) u_dut (
    .clk               (clk),
    .rst               (rst),
    .sample_tick       (sample_tick),
    .play              (play),
    .dir               (dir),
    .loop              (loop),
    .restart           (restart),
    .flsh_address      (flsh_address),
    .flsh_read         (flsh_read),
    .flsh_waitrequest  (flsh_waitrequest),
    .flsh_readdata     (flsh_readdata),
    .flsh_readdatavalid(flsh_readdatavalid),
    .flsh_byteenable   (flsh_byteenable),
    .audio_out         (audio_out),
    .audio_valid       (audio_valid),
    .done              (done),
    .overrun           (overrun)
  );

  logic [DATA_W-1:0] mem [START:ENDA];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: absolute sample index within the clip
  int pos;
  bit have_word;
  bit m_done;
  bit m_ovr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SAMPLE_W-1:0] sample_at(input int p);
    logic [DATA_W-1:0] w;
    w = mem[p / N];
    return w[(p % N) * SAMPLE_W +: SAMPLE_W];
  endfunction

  function automatic logic [DATA_W-1:0] slave_word(input logic [ADDR_W-1:0] a);
    if (a > ADDR_W'(ENDA)) return 32'hDEAD_BEEF;
    return mem[int'(a)];
  endfunction

  function automatic void model_reset();
    pos = FIRST; have_word = 0; m_done = 0; m_ovr = 0;
  endfunction

  function automatic void model_restart(input bit d);
    pos = d ? LAST : FIRST; have_word = 0; m_done = 0; m_ovr = 0;
  endfunction

  // Move to the next sample of the clip in direction d
  function automatic void model_advance(input bit d, input bit lp);
    int nxt;
    bit crossing;
    nxt      = d ? pos - 1 : pos + 1;
    crossing = d ? (pos % N == 0) : (pos % N == N - 1);
    if (!crossing) begin
      pos = nxt;
    end else begin
      have_word = 0;
      if (nxt < FIRST || nxt > LAST) begin
        if (lp) pos = d ? LAST : FIRST;
        else begin
          m_done = 1;
          pos = (pos / N) * N + (d ? N - 1 : 0);
        end
      end else begin
        pos = nxt;
      end
    end
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_addr"}, flsh_address, pos / N);
    chk({tag, "_done"}, done, m_done);
    chk({tag, "_ovr"}, overrun, m_ovr);
  endtask

  // One tick with play=pl. inj raises another tick while busy and rs raises
  // restart while busy. w = waitrequest cycles, dl = read latency cycles.
  task automatic do_tick(input bit d, input bit lp, input bit pl, input bit inj,
                         input bit rs, input int w, input int dl);
    logic [SAMPLE_W-1:0] exp_s;
    logic [ADDR_W-1:0]   ra;
    int                  rd_cycles;
    dir = d; loop = lp; play = pl; sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    if (!pl || m_done) begin
      chk("ignored_read", flsh_read, 0);
      chk("ignored_valid", audio_valid, 0);
      step();
      chk("ignored_read2", flsh_read, 0);
    end else begin
      exp_s = sample_at(pos);
      if (!have_word) begin
        rd_cycles = 0;
        ra = '0;
        for (int i = 0; i <= w; i++) begin
          if (flsh_read) rd_cycles++;
          chk("req_addr", flsh_address, pos / N);
          chk("req_novalid", audio_valid, 0);
          ra = flsh_address;
          flsh_waitrequest = (i < w);
          sample_tick = inj && (i == 0);
          restart = rs && (i == 0);
          step();
          sample_tick = 1'b0;
          restart = 1'b0;
        end
        flsh_waitrequest = 1'b0;
        chk("read_cycles", rd_cycles, w + 1);
        chk("read_dropped", flsh_read, 0);
        for (int j = 0; j < dl; j++) begin
          step();
          chk("wait_novalid", audio_valid, 0);
          chk("wait_noread", flsh_read, 0);
        end
        flsh_readdata = slave_word(ra);
        flsh_readdatavalid = 1'b1;
        step();
        flsh_readdatavalid = 1'b0;
        flsh_readdata = $urandom;
        have_word = 1;
        if (inj) m_ovr = 1;
      end else begin
        chk("buf_noread", flsh_read, 0);
        sample_tick = inj;
        restart = rs;
        if (inj) m_ovr = 1;
      end
      chk("valid", audio_valid, 1);
      chk("sample", audio_out, exp_s);
      if (rs) model_restart(d);
      else model_advance(d, lp);
      step();
      sample_tick = 1'b0;
      restart = 1'b0;
      chk("valid_pulse", audio_valid, 0);
      chk("sample_hold", audio_out, exp_s);
    end
    check_idle("tick");
  endtask

  task automatic do_restart(input bit d, input bit with_tick);
    dir = d; play = 1'b1; restart = 1'b1; sample_tick = with_tick;
    step();
    restart = 1'b0; sample_tick = 1'b0;
    model_restart(d);
    chk("rst_noread", flsh_read, 0);
    chk("rst_novalid", audio_valid, 0);
    check_idle("restart");
  endtask

  initial begin
    for (int a = START; a <= ENDA; a++) mem[a] = $urandom;
    mem[0] = 32'hBBBB_AAAA;

    // Reset values
    step();
    chk("reset_addr", flsh_address, START);
    chk("reset_read", flsh_read, 0);
    chk("reset_valid", audio_valid, 0);
    chk("reset_audio", audio_out, 0);
    chk("reset_done", done, 0);
    chk("reset_ovr", overrun, 0);
    chk("byteenable", flsh_byteenable, 4'hF);
    rst = 1'b1;
    model_reset();
    step();

    // Two forward ticks from address 0: fetch, then buffered
    do_tick(0, 0, 1, 0, 0, 0, 0);
    chk("first_sample", audio_out, 16'hAAAA);
    do_tick(0, 0, 1, 0, 0, 0, 1);
    chk("second_sample", audio_out, 16'hBBBB);

    // Stalled read: read held four cycles
    do_tick(0, 0, 1, 0, 0, 3, 2);

    // Forward without loop runs to done
    do_restart(0, 0);
    for (int i = 0; i < 6; i++) do_tick(0, 0, 1, 0, 0, i % 3, i % 2);
    chk("end_done", done, 1);
    do_tick(0, 0, 1, 0, 0, 0, 0);

    // Reverse with loop wraps from start back to END_ADDR
    do_restart(1, 0);
    chk("rev_start_addr", flsh_address, ENDA);
    for (int i = 0; i < 7; i++) do_tick(1, 1, 1, 0, 0, 0, 1);

    // Overrun and its clearing
    do_restart(0, 0);
    do_tick(0, 0, 1, 1, 0, 1, 2);
    chk("ovr_set", overrun, 1);
    do_restart(0, 0);
    chk("ovr_clear", overrun, 0);

    // Restart latched during a fetch, and restart colliding with a tick
    do_tick(0, 1, 1, 0, 0, 0, 0);
    do_tick(0, 1, 1, 0, 1, 0, 1);
    chk("pend_addr", flsh_address, START);
    do_tick(0, 1, 1, 0, 0, 0, 0);
    do_restart(1, 1);

    // Asynchronous reset while waiting for read data
    do_restart(0, 0);
    dir = 0; play = 1; sample_tick = 1'b1;
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_read", flsh_read, 0);
    chk("arst_valid", audio_valid, 0);
    chk("arst_audio", audio_out, 0);
    chk("arst_ovr", overrun, 0);
    chk("arst_addr", flsh_address, START);
    rst = 1'b1;
    model_reset();
    flsh_readdata = mem[0];
    flsh_readdatavalid = 1'b1;
    step();
    flsh_readdatavalid = 1'b0;
    chk("late_rdv_valid", audio_valid, 0);
    step();
    chk("late_rdv_valid2", audio_valid, 0);
    check_idle("after_arst");

    // Randomized playback
    for (int k = 0; k < 300; k++) begin
      int op;
      bit d, lp, inj, rs;
      op  = $urandom_range(0, 9);
      d   = 1'($urandom_range(0, 1));
      lp  = 1'($urandom_range(0, 1));
      inj = ($urandom_range(0, 5) == 0);
      rs  = !inj && ($urandom_range(0, 7) == 0);
      if (op == 0 || (m_done && op < 4)) begin
        do_restart(d, 1'($urandom_range(0, 1)));
      end else begin
        do_tick(d, lp, op != 1, inj, rs, $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
